// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the bit-serial MSB-first magnitude comparator.
package serial_cmp_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // Accumulated comparison verdict while scanning from MSB to LSB.
  typedef enum logic [1:0] {
    RES_EQ,
    RES_LT,
    RES_GT
  } cmp_res_t;

  // Map a verdict onto the {lt, eq, gt} one-hot output triple.
  function automatic logic [2:0] res_to_onehot(cmp_res_t res);
    case (res)
      RES_LT:  return 3'b100;
      RES_GT:  return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

endpackage

// File: rtl/serial_msb_first_comparator_if.sv
// Operand/result handshake bundle for the serial comparator.
// The slave modport is the comparator's view; the master modport is its user's view.
interface serial_msb_first_comparator_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             lt;
  logic             eq;
  logic             gt;
  logic             busy;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, lt, eq, gt, busy
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, lt, eq, gt, busy
  );

endinterface

// File: rtl/serial_msb_first_comparator_step.sv
// One bit-step of the MSB-first comparison. A verdict already reached on
// higher-order bits wins; only while still equal does the current bit pair decide.
module msb_first_cmp_step
  import serial_cmp_pkg::*;
(
  input  logic     a_bit,
  input  logic     b_bit,
  input  cmp_res_t acc_in,
  output cmp_res_t acc_out
);

  // Sticky verdict update from the current bit pair.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    acc_out = acc_in;
    if (acc_in == RES_EQ && a_bit != b_bit) begin
      acc_out = a_bit ? RES_GT : RES_LT;
    end
  end

endmodule

// File: rtl/serial_msb_first_comparator.sv
// Bit-serial unsigned magnitude comparator, one bit per clock, MSB first.
// Operands are accepted on an in_valid/in_ready handshake and the one-hot
// lt/eq/gt result is returned on an out_valid/out_ready handshake.
// Build option: define SERIAL_CMP_EARLY_EXIT_EN to leave SCAN on the first
// differing bit; left undefined, SCAN always takes WIDTH cycles so latency is
// independent of the operand values.
module serial_msb_first_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                         clk,
  input logic                         rst_n,
  serial_msb_first_comparator_if.slave bus
);

  // Sized so the count can reach WIDTH without wrapping.
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmp_res_t         acc_q, acc_d;
  cmp_res_t         acc_step;
  logic [2:0]       res_q, res_d;
  logic             out_valid_q, out_valid_d;
  logic             last_bit;
  logic             scan_exit;

  msb_first_cmp_step u_step (
    .a_bit   (sa_q[WIDTH-1]),
    .b_bit   (sb_q[WIDTH-1]),
    .acc_in  (acc_q),
    .acc_out (acc_step)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  // Leave as soon as the verdict is decided; equal operands still scan all bits.
  assign scan_exit = last_bit || (acc_step != RES_EQ);
`else
  // Always scan every bit so latency does not depend on the data.
  assign scan_exit = last_bit;
`endif

  // Next-state, datapath and result-load logic.
  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          cnt_d   = '0;
          acc_d   = RES_EQ;
          state_d = SCAN;
        end
      end
      SCAN: begin
        acc_d = acc_step;
        sa_d  = sa_q << 1;
        sb_d  = sb_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (scan_exit) begin
          res_d       = res_to_onehot(acc_step);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand shift registers are plain flops, not a memory, so they are reset along with the rest.
    if (!rst_n) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= RES_EQ;
      res_q       <= 3'b000;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == SCAN);
  assign bus.out_valid = out_valid_q;
  assign bus.lt        = res_q[2];
  assign bus.eq        = res_q[1];
  assign bus.gt        = res_q[0];

endmodule

// File: tb/tb_serial_msb_first_comparator.sv
// Scoreboard bench for serial_msb_first_comparator (WIDTH=8). The driver
// pushes the expected one-hot verdict and result edge for every accepted pair;
// an independent monitor pops and compares whenever a new result appears.
// Honours SERIAL_CMP_EARLY_EXIT_EN the same way the design does.
module tb_serial_msb_first_comparator;

  localparam int WIDTH = 8;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [2:0] onehot;
    int         exp_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_msb_first_comparator_if #(.WIDTH(WIDTH)) bus ();

  serial_msb_first_comparator #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: plain unsigned ordering, result as {lt, eq, gt}.
  function automatic logic [2:0] ref_onehot(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    return {a < b, a == b, a > b};
  endfunction

  // Reference latency in edges after the accepting edge.
  function automatic int ref_latency(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    int diff;
    if (!EARLY || a == b) return WIDTH;
    diff = int'(a ^ b);
    // Highest differing bit position p = $clog2(diff+1)-1; MSB-relative index j = WIDTH-1-p.
    return WIDTH + 1 - $clog2(diff + 1);
  endfunction

  // Present one pair, wait for acceptance, record expectation.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("in_ready_timeout", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
    e.onehot   = ref_onehot(a, b);
    e.exp_edge = cyc + ref_latency(a, b);
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  // Monitor: one-hot invariant, hold under backpressure, scoreboard pop on each new result.
  initial begin
    logic       v_before;
    logic       hs;
    logic [2:0] res_before;
    logic [2:0] cur;
    exp_t       e;
    forever begin
      @(posedge clk);
      v_before   = bus.out_valid;
      hs         = bus.out_valid && bus.out_ready;
      res_before = {bus.lt, bus.eq, bus.gt};
      #1;
      if (rst_n) begin
        cur = {bus.lt, bus.eq, bus.gt};
        if (bus.out_valid) check("onehot", $countones(cur), 1);
        if (v_before && !hs) begin
          check("hold_valid", int'(bus.out_valid), 1);
          check("hold_result", int'(cur), int'(res_before));
        end else if (bus.out_valid) begin
          check("result_expected", sb.size() > 0 ? 1 : 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("result", int'(cur), int'(e.onehot));
            check("latency_edge", cyc, e.exp_edge);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_result", int'({bus.lt, bus.eq, bus.gt}), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Directed patterns.
    issue(8'hA5, 8'h5A);
    wait_drain();
    issue(8'h3C, 8'h3C);
    wait_drain();
    issue(8'h10, 8'h11);
    wait_drain();
    issue(8'h00, 8'hFF);
    check("busy_while_scan", int'(bus.busy), (ref_latency(8'h00, 8'hFF) > 1) ? 1 : 0);
    wait_drain();

    // Backpressure: result held, new operands ignored while not idle.
    bus.out_ready = 1'b0;
    issue(8'h12, 8'h34);
    begin
      int t;
      t = 0;
      while (!bus.out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("bp_out_valid_seen", int'(bus.out_valid), 1);
    end
    repeat (5) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 8'hFF;
      bus.b        = 8'h00;
      check("bp_in_ready_low", int'(bus.in_ready), 0);
      check("bp_out_valid_held", int'(bus.out_valid), 1);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", int'(bus.out_valid), 0);
    check("bp_release_in_ready", int'(bus.in_ready), 1);
    wait_drain();

    // Reset in the middle of a scan: no result may follow.
    issue(8'h01, 8'h02);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_result", int'({bus.lt, bus.eq, bus.gt}), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 1);
    check("mid_rst_busy", int'(bus.busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_no_result", int'(bus.out_valid), 0);
    check("post_rst_idle", int'(bus.in_ready), 1);

    // Back-to-back random pairs with the consumer always ready.
    for (int i = 0; i < 200; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      issue(ra, rb);
    end
    wait_drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
